// File: rtl/mem_arbiter_multiport.sv
// Multi-port arbiter onto a byte-serial RAM/IO bus: per-port valid/grant handshake,
// byte-wise issue with stall handling, sign/zero-extended loads and read flush.
module mem_arbiter_multiport #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 32,
    parameter int MAX_BYTES = 4,
    parameter int RR_MODE   = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rdy,
    input  logic                              io_buffer_full,
    input  logic [7:0]                        mem_din,
    output logic [7:0]                        mem_dout,
    output logic [ADDR_W-1:0]                 mem_a,
    output logic                              mem_wr,
    input  logic [NUM_PORTS-1:0]              req_valid,
    input  logic [NUM_PORTS-1:0]              req_write,
    input  logic [NUM_PORTS-1:0]              req_signed,
    input  logic [2*NUM_PORTS-1:0]            req_size,
    input  logic [ADDR_W*NUM_PORTS-1:0]       req_addr,
    input  logic [8*MAX_BYTES*NUM_PORTS-1:0]  req_wdata,
    input  logic [NUM_PORTS-1:0]              flush,
    output logic [NUM_PORTS-1:0]              req_grant,
    output logic [NUM_PORTS-1:0]              resp_valid,
    output logic [8*MAX_BYTES-1:0]            resp_rdata,
    output logic                              busy
);
    localparam int DW     = 8 * MAX_BYTES;
    localparam int SZ_MAX = $clog2(MAX_BYTES);
    localparam int CW     = SZ_MAX + 1;
    localparam int PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     ptr_reg, ptr_next, port_reg, port_next;
    logic              signed_reg, signed_next;
    logic [CW-1:0]     len_reg, len_next, cnt_reg, cnt_next;
    logic [CW-1:0]     lane_reg, lane_next, cap_lane_reg, cap_lane_next;
    logic              pend_reg, pend_next, cap_reg, cap_next;
    logic [ADDR_W-1:0] addr_reg, addr_next, mem_a_reg, mem_a_next;
    logic [DW-1:0]     wdata_reg, wdata_next, lanes_reg, lanes_next;
    logic [DW-1:0]     rdata_reg, rdata_next, ext_data, wdata_shift;
    logic              mem_wr_reg, mem_wr_next;
    logic [7:0]        mem_dout_reg, mem_dout_next;

    logic [PW-1:0]     grant_idx, cand;
    logic              grant_found, grant_go, issue_ok, resp_fire, sign_bit;
    logic [1:0]        g_size;
    logic [CW-1:0]     g_len;
    logic [ADDR_W-1:0] g_addr;
    logic [DW-1:0]     g_wdata;

    // Round-robin scans from the port after the pointer; the pointer itself ranks last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (RR_MODE != 0) begin
            for (int off = NUM_PORTS; off >= 1; off--) begin
                cand = PW'((int'(ptr_reg) + off) % NUM_PORTS);
                if (req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end else begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = PW'(i);
                end
            end
        end
    end

    assign g_size      = req_size[int'(grant_idx)*2 +: 2];
    assign g_addr      = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    assign g_wdata     = req_wdata[int'(grant_idx)*DW +: DW];
    assign issue_ok    = rdy && !io_buffer_full;
    assign grant_go    = (state_reg == IDLE) && rdy && grant_found && !rst;
    assign resp_fire   = (state_reg == RESP) && rdy;
    assign wdata_shift = wdata_reg >> {cnt_reg, 3'b000};

    always_comb begin
        if (int'(g_size) > SZ_MAX) g_len = CW'(1) << SZ_MAX;
        else                       g_len = CW'(1) << g_size;
    end

    // Read capture runs even while stalled: the byte was already requested.
    always_comb begin
        lanes_next = lanes_reg;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (state_reg == READ && cap_reg && cap_lane_reg == CW'(k))
                lanes_next[8*k +: 8] = mem_din;
        end
    end

    always_comb begin
        sign_bit = 1'b0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (len_reg == CW'(k + 1)) sign_bit = lanes_next[8*k + 7];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_BYTES; gi++) begin : g_ext
            assign ext_data[8*gi +: 8] = (CW'(gi) < len_reg) ? lanes_next[8*gi +: 8]
                                                             : {8{signed_reg & sign_bit}};
        end
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign req_grant[gi]  = grant_go && (grant_idx == PW'(gi));
            assign resp_valid[gi] = resp_fire && (port_reg == PW'(gi));
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        port_next     = port_reg;
        signed_next   = signed_reg;
        len_next      = len_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        cnt_next      = cnt_reg;
        lane_next     = lane_reg;
        pend_next     = 1'b0;
        cap_next      = 1'b0;
        cap_lane_next = lane_reg;
        rdata_next    = rdata_reg;
        mem_a_next    = mem_a_reg;
        mem_wr_next   = 1'b0;
        mem_dout_next = mem_dout_reg;
        unique case (state_reg)
            IDLE: begin
                mem_a_next    = '0;
                mem_dout_next = '0;
                if (grant_go) begin
                    port_next   = grant_idx;
                    ptr_next    = grant_idx;
                    signed_next = req_signed[grant_idx];
                    len_next    = g_len;
                    addr_next   = g_addr;
                    wdata_next  = g_wdata;
                    cnt_next    = '0;
                    lane_next   = '0;
                    mem_a_next  = g_addr;
                    state_next  = req_write[grant_idx] ? WRITE : READ;
                    // A full IO buffer at grant time defers byte 0 to the data state.
                    if (issue_ok) begin
                        cnt_next      = CW'(1);
                        mem_wr_next   = req_write[grant_idx];
                        mem_dout_next = req_write[grant_idx] ? g_wdata[7:0] : 8'h00;
                        pend_next     = !req_write[grant_idx];
                    end
                end
            end
            READ: begin
                cap_next = pend_reg;
                if (flush[port_reg]) begin
                    state_next = IDLE;
                    mem_a_next = '0;
                    cap_next   = 1'b0;
                end else if (cnt_reg == len_reg) begin
                    if (!pend_reg && rdy) begin
                        state_next = RESP;
                        rdata_next = ext_data;
                        mem_a_next = '0;
                    end
                end else if (issue_ok) begin
                    mem_a_next = addr_reg + ADDR_W'(cnt_reg);
                    pend_next  = 1'b1;
                    lane_next  = cnt_reg;
                    cnt_next   = cnt_reg + CW'(1);
                end
            end
            WRITE: begin
                if (cnt_reg == len_reg) begin
                    if (rdy) begin
                        state_next    = RESP;
                        mem_a_next    = '0;
                        mem_dout_next = '0;
                    end
                end else if (issue_ok) begin
                    mem_a_next    = addr_reg + ADDR_W'(cnt_reg);
                    mem_dout_next = wdata_shift[7:0];
                    mem_wr_next   = 1'b1;
                    cnt_next      = cnt_reg + CW'(1);
                end
            end
            RESP: begin
                if (rdy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= PW'(NUM_PORTS - 1);
            port_reg     <= '0;
            signed_reg   <= 1'b0;
            len_reg      <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            cnt_reg      <= '0;
            lane_reg     <= '0;
            pend_reg     <= 1'b0;
            cap_reg      <= 1'b0;
            cap_lane_reg <= '0;
            lanes_reg    <= '0;
            rdata_reg    <= '0;
            mem_a_reg    <= '0;
            mem_wr_reg   <= 1'b0;
            mem_dout_reg <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            port_reg     <= port_next;
            signed_reg   <= signed_next;
            len_reg      <= len_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            cnt_reg      <= cnt_next;
            lane_reg     <= lane_next;
            pend_reg     <= pend_next;
            cap_reg      <= cap_next;
            cap_lane_reg <= cap_lane_next;
            lanes_reg    <= lanes_next;
            rdata_reg    <= rdata_next;
            mem_a_reg    <= mem_a_next;
            mem_wr_reg   <= mem_wr_next;
            mem_dout_reg <= mem_dout_next;
        end
    end

    assign mem_a      = mem_a_reg;
    assign mem_wr     = mem_wr_reg;
    assign mem_dout   = mem_dout_reg;
    assign resp_rdata = rdata_reg;
    assign busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_mem_arbiter_multiport.sv
// Directed bench for mem_arbiter_multiport: a round-robin instance and a
// fixed-priority instance share stimulus; a small RAM model feeds mem_din.
module tb_mem_arbiter_multiport;
    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rst, rdy, io_buffer_full;
    logic [7:0]       mem_din;
    logic [NP-1:0]    req_valid, req_write, req_signed, flush;
    logic [2*NP-1:0]  req_size;
    logic [AW*NP-1:0] req_addr;
    logic [DW*NP-1:0] req_wdata;

    logic [7:0]       mem_dout, fp_mem_dout;
    logic [AW-1:0]    mem_a, fp_mem_a;
    logic             mem_wr, fp_mem_wr, busy, fp_busy;
    logic [NP-1:0]    req_grant, resp_valid, fp_req_grant, fp_resp_valid;
    logic [DW-1:0]    resp_rdata, fp_resp_rdata;

    int total = 0;
    int bad   = 0;
    logic [7:0] ram [0:255];
    logic [2:0] exp_oh;

    mem_arbiter_multiport #(.NUM_PORTS(NP), .ADDR_W(AW), .MAX_BYTES(4), .RR_MODE(1)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .req_valid(req_valid), .req_write(req_write), .req_signed(req_signed),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
        .req_grant(req_grant), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy)
    );

    mem_arbiter_multiport #(.NUM_PORTS(NP), .ADDR_W(AW), .MAX_BYTES(4), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(fp_mem_dout), .mem_a(fp_mem_a), .mem_wr(fp_mem_wr),
        .req_valid(req_valid), .req_write(req_write), .req_signed(req_signed),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
        .req_grant(fp_req_grant), .resp_valid(fp_resp_valid), .resp_rdata(fp_resp_rdata),
        .busy(fp_busy)
    );

    always #5 clk = ~clk;

    // RAM returns the byte addressed in the previous cycle.
    always @(posedge clk) mem_din <= ram[mem_a[7:0]];

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input bit wr, input bit sg, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d);
        req_valid[p]          = 1'b1;
        req_write[p]          = wr;
        req_signed[p]         = sg;
        req_size[2*p +: 2]    = sz;
        req_addr[p*AW +: AW]  = a;
        req_wdata[p*DW +: DW] = d;
    endtask

    // Single load with no stalls; resp_valid expected exactly lat cycles after grant.
    task automatic do_load(input int p, input bit sg, input logic [1:0] sz, input logic [31:0] a,
                           input int lat, input logic [31:0] exp, input string tag);
        logic [2:0] oh;
        oh = 3'b001 << p;
        set_req(p, 1'b0, sg, sz, a, 32'h0);
        #1 chk({tag, "_grant"}, req_grant, oh);
        nxt();
        req_valid = '0;
        repeat (lat - 2) nxt();
        chk({tag, "_early"}, resp_valid, 3'b000);
        nxt();
        chk({tag, "_resp"}, resp_valid, oh);
        chk({tag, "_data"}, resp_rdata, exp);
        $display("load %s port=%0d addr=%h rdata=%h", tag, p, a, resp_rdata);
        nxt();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
        req_valid = '0; req_write = '0; req_signed = '0; req_size = '0;
        req_addr = '0; req_wdata = '0; flush = '0;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[8'h00] = 8'h11; ram[8'h01] = 8'h22; ram[8'h02] = 8'h33; ram[8'h03] = 8'h44;
        ram[8'h10] = 8'h80;
        ram[8'h20] = 8'hFF; ram[8'h21] = 8'h7F;
        ram[8'h30] = 8'h01; ram[8'h31] = 8'h80;
        req_valid = 3'b001;
        nxt(); nxt();

        // Reset state, with a request held during reset that must not be granted
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_mem_dout", mem_dout, 8'h00);
        chk("rst_grant", req_grant, 3'b000);
        chk("rst_resp", resp_valid, 3'b000);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_busy", busy, 1'b0);
        req_valid = '0;
        rst = 1'b0;
        nxt();

        // 4-byte load, port 1, address 0x100
        set_req(1, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
        #1 chk("ld4_grant", req_grant, 3'b010);
        chk("ld4_busy_g", busy, 1'b0);
        for (int k = 0; k < 4; k++) begin
            nxt();
            if (k == 0) req_valid = '0;
            chk("ld4_addr", mem_a, 32'h100 + k);
            chk("ld4_wr", mem_wr, 1'b0);
        end
        nxt();
        chk("ld4_early", resp_valid, 3'b000);
        nxt();
        chk("ld4_resp", resp_valid, 3'b010);
        chk("ld4_data", resp_rdata, 32'h44332211);
        $display("load ld4 port=1 addr=00000100 rdata=%h", resp_rdata);
        nxt();
        chk("ld4_idle_busy", busy, 1'b0);
        chk("ld4_idle_a", mem_a, 32'h0);
        chk("ld4_idle_resp", resp_valid, 3'b000);

        // Extension and size clamp
        do_load(0, 1'b1, 2'd0, 32'h10, 3, 32'hFFFFFF80, "ld1s");
        do_load(0, 1'b0, 2'd0, 32'h10, 3, 32'h00000080, "ld1u");
        do_load(2, 1'b1, 2'd1, 32'h20, 4, 32'h00007FFF, "ld2s_pos");
        do_load(2, 1'b1, 2'd1, 32'h30, 4, 32'hFFFF8001, "ld2s_neg");
        do_load(1, 1'b0, 2'd3, 32'h100, 6, 32'h44332211, "ld_clamp");

        // 2-byte store with io_buffer_full high for 3 cycles after byte 0
        set_req(2, 1'b1, 1'b0, 2'd1, 32'h30004, 32'h0000BEEF);
        #1 chk("st_grant", req_grant, 3'b100);
        nxt();
        req_valid = '0;
        io_buffer_full = 1'b1;
        chk("st_b0_a", mem_a, 32'h30004);
        chk("st_b0_d", mem_dout, 8'hEF);
        chk("st_b0_wr", mem_wr, 1'b1);
        nxt(); chk("st_stall1_wr", mem_wr, 1'b0);
        nxt(); chk("st_stall2_wr", mem_wr, 1'b0);
        nxt(); chk("st_stall3_wr", mem_wr, 1'b0);
        io_buffer_full = 1'b0;
        nxt();
        chk("st_b1_a", mem_a, 32'h30005);
        chk("st_b1_d", mem_dout, 8'hBE);
        chk("st_b1_wr", mem_wr, 1'b1);
        chk("st_early", resp_valid, 3'b000);
        nxt();
        chk("st_resp", resp_valid, 3'b100);
        chk("st_wr_end", mem_wr, 1'b0);
        $display("store port=2 addr=00030004 data=beef");
        nxt();
        chk("st_idle_a", mem_a, 32'h0);

        // All three ports request continuously
        set_req(0, 1'b1, 1'b0, 2'd0, 32'h40, 32'h0);
        set_req(1, 1'b1, 1'b0, 2'd0, 32'h41, 32'h1);
        set_req(2, 1'b1, 1'b0, 2'd0, 32'h42, 32'h2);
        #1;
        for (int t = 0; t < 6; t++) begin
            exp_oh = 3'b001 << (t % 3);
            chk("rr_grant", req_grant, exp_oh);
            chk("fp_grant", fp_req_grant, 3'b001);
            nxt();
            chk("rr_nogrant", req_grant, 3'b000);
            nxt();
            chk("rr_resp", resp_valid, exp_oh);
            chk("fp_resp", fp_resp_valid, 3'b001);
            $display("contention transfer %0d rr_port_onehot=%b fp_port_onehot=%b", t, resp_valid, fp_resp_valid);
            if (t == 5) req_valid = '0;
            nxt();
        end

        // Flush port 0 during its second issued byte; port 1 waits
        set_req(0, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
        set_req(1, 1'b0, 1'b0, 2'd0, 32'h10, 32'h0);
        #1 chk("fl_grant0", req_grant, 3'b001);
        nxt();
        req_valid[0] = 1'b0;
        nxt();
        flush[0] = 1'b1;
        chk("fl_b1_a", mem_a, 32'h101);
        chk("fl_busy", busy, 1'b1);
        nxt();
        flush = '0;
        chk("fl_idle_busy", busy, 1'b0);
        chk("fl_noresp", resp_valid, 3'b000);
        chk("fl_grant1", req_grant, 3'b010);
        nxt();
        req_valid = '0;
        nxt();
        chk("fl_p1_early", resp_valid, 3'b000);
        nxt();
        chk("fl_p1_resp", resp_valid, 3'b010);
        chk("fl_p1_data", resp_rdata, 32'h00000080);
        $display("flush port=0 aborted, port=1 rdata=%h", resp_rdata);
        nxt();

        // rdy low for 2 cycles mid-load and for 2 cycles during RESP
        set_req(2, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
        #1 chk("rdy_grant", req_grant, 3'b100);
        nxt();
        req_valid = '0;
        nxt();
        rdy = 1'b0;
        nxt();
        chk("rdy_stall_resp", resp_valid, 3'b000);
        nxt();
        rdy = 1'b1;
        chk("rdy_hold_a", mem_a, 32'h101);
        nxt();
        chk("rdy_resume_a", mem_a, 32'h102);
        nxt();
        nxt();
        chk("rdy_busy", busy, 1'b1);
        chk("rdy_pre_resp", resp_valid, 3'b000);
        nxt();
        rdy = 1'b0;
        #1 chk("rdy_resp_held1", resp_valid, 3'b000);
        chk("rdy_resp_busy", busy, 1'b1);
        nxt();
        chk("rdy_resp_held2", resp_valid, 3'b000);
        nxt();
        rdy = 1'b1;
        #1 chk("rdy_resp", resp_valid, 3'b100);
        chk("rdy_data", resp_rdata, 32'h44332211);
        $display("load rdy_stall port=2 addr=00000100 rdata=%h", resp_rdata);
        nxt();
        chk("rdy_resp_once", resp_valid, 3'b000);
        chk("rdy_idle", busy, 1'b0);

        // Reset in the middle of a 4-byte store
        set_req(0, 1'b1, 1'b0, 2'd2, 32'h200, 32'hA1B2C3D4);
        #1 chk("rs_grant", req_grant, 3'b001);
        nxt();
        req_valid = '0;
        chk("rs_b0_wr", mem_wr, 1'b1);
        chk("rs_b0_d", mem_dout, 8'hD4);
        nxt();
        rst = 1'b1;
        nxt();
        chk("rs_mem_a", mem_a, 32'h0);
        chk("rs_mem_wr", mem_wr, 1'b0);
        chk("rs_mem_dout", mem_dout, 8'h00);
        chk("rs_busy", busy, 1'b0);
        chk("rs_resp", resp_valid, 3'b000);
        chk("rs_rdata", resp_rdata, 32'h0);
        chk("rs_grant_off", req_grant, 3'b000);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nxt();
            chk("rs_noresp", resp_valid, 3'b000);
        end
        $display("store port=0 addr=00000200 abandoned by reset");

        // Pointer back at NUM_PORTS-1 after reset: port 0 beats port 2
        set_req(0, 1'b0, 1'b0, 2'd0, 32'h10, 32'h0);
        set_req(2, 1'b0, 1'b0, 2'd0, 32'h10, 32'h0);
        #1 chk("rs_ptr_grant", req_grant, 3'b001);
        nxt();
        req_valid = '0;
        repeat (8) nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
